change_dispenser: RTL and testbench

Change-return controller that sits downstream of the item FSMs and drives the coin-return hopper. It accepts a refund or change request in nickel units over a valid/ready handshake. It then pays the amount out as single-cycle dime/nickel pulses, tracking on-board hopper inventory. It reports any shortfall it could not pay.

---
 rtl/change_dispenser.sv | 131 +++++++++++++
 tb/tb_change_dispenser.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: coin-return controller. It accepts a change amount in
// nickel units and pays it out greedily, dimes first, as single-cycle pulses.
// It tracks hopper stock and reports any unpaid remainder.
// Optional feature: define CHANGE_DISPENSER_AUDIT_EN to add the paid_total
// running counter output.
module change_dispenser #(
  parameter int AMT_W       = 4,
  parameter int INV_W       = 6,
  parameter int NICKEL_INIT = 20,
  parameter int DIME_INIT   = 20
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  input  logic             hopper_busy,
  input  logic             refill,
  output logic             nickel_out,
  output logic             dime_out,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] short_amount,
  output logic [INV_W-1:0] nickel_stock,
  output logic [INV_W-1:0] dime_stock
`ifdef CHANGE_DISPENSER_AUDIT_EN
  ,
  output logic [15:0]      paid_total
`endif
);

  typedef enum logic [2:0] {IDLE, EVAL, DIME, NICKEL, GAP, DONE} state_t;

  state_t           state, state_nxt;
  logic [AMT_W-1:0] rem;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: one coin decision per EVAL visit, dimes preferred.
  // A dime needs rem>=2 so the customer is never overpaid.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (req_valid) state_nxt = EVAL;
      EVAL: begin
        if (!hopper_busy) begin
          if (rem >= AMT_W'(2) && dime_stock != '0)
            state_nxt = DIME;
          else if (rem != '0 && nickel_stock != '0)
            state_nxt = NICKEL;
          else
            state_nxt = DONE;
        end
      end
      DIME:   state_nxt = GAP;
      NICKEL: state_nxt = GAP;
      GAP:    state_nxt = EVAL;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs decoded from state only.
  always_comb begin
    req_ready  = (state == IDLE);
    dime_out   = (state == DIME);
    nickel_out = (state == NICKEL);
    done       = (state == DONE);
  end

  // Datapath: remainder, stocks and shortfall. Coin side-effects are applied
  // on the EVAL->coin edge so stock changes line up with the pulse cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      rem          <= '0;
      nickel_stock <= INV_W'(NICKEL_INIT);
      dime_stock   <= INV_W'(DIME_INIT);
      short        <= 1'b0;
      short_amount <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (refill) begin
            nickel_stock <= INV_W'(NICKEL_INIT);
            dime_stock   <= INV_W'(DIME_INIT);
          end
          if (req_valid) begin
            rem          <= req_amount;
            short        <= 1'b0;
            short_amount <= '0;
          end
        end
        EVAL: begin
          case (state_nxt)
            DIME: begin
              rem        <= rem - AMT_W'(2);
              dime_stock <= dime_stock - INV_W'(1);
            end
            NICKEL: begin
              rem          <= rem - AMT_W'(1);
              nickel_stock <= nickel_stock - INV_W'(1);
            end
            DONE: begin
              short        <= (rem != '0);
              short_amount <= rem;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

`ifdef CHANGE_DISPENSER_AUDIT_EN
  // Running total of nickel units ejected; survives refill, wraps at 2^16.
  always_ff @(posedge clock) begin
    if (reset)
      paid_total <= '0;
    else if (state == EVAL && state_nxt == DIME)
      paid_total <= paid_total + 16'd2;
    else if (state == EVAL && state_nxt == NICKEL)
      paid_total <= paid_total + 16'd1;
  end
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed stimulus, a cycle-timed behavioural model
// compared every cycle, plus literal expectations from hand-worked timing.
module tb_change_dispenser;
  localparam int AMT_W = 4;
  localparam int INV_W = 6;
  localparam int NI    = 20;
  localparam int DI    = 20;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic             reset = 1'b1, req_valid = 1'b0, hopper_busy = 1'b0, refill = 1'b0;
  logic [AMT_W-1:0] req_amount = '0;
  logic             req_ready, nickel_out, dime_out, done, short;
  logic [AMT_W-1:0] short_amount;
  logic [INV_W-1:0] nickel_stock, dime_stock;
`ifdef CHANGE_DISPENSER_AUDIT_EN
  logic [15:0]      paid_total;
`endif

  change_dispenser #(.AMT_W(AMT_W), .INV_W(INV_W), .NICKEL_INIT(NI), .DIME_INIT(DI)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_amount(req_amount),
    .req_ready(req_ready), .hopper_busy(hopper_busy), .refill(refill),
    .nickel_out(nickel_out), .dime_out(dime_out), .done(done), .short(short),
    .short_amount(short_amount), .nickel_stock(nickel_stock), .dime_stock(dime_stock)
`ifdef CHANGE_DISPENSER_AUDIT_EN
    , .paid_total(paid_total)
`endif
  );

  int checks = 0, failures = 0;
  int cyc = 0;
  int dq[$], nq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Model: absolute cycle numbers of the next coin decision, pulses and done.
  bit m_idle = 1;
  int m_eval = -1, m_dime = -1, m_nick = -1, m_done = -1;
  int m_rem = 0, m_d = DI, m_n = NI, m_short = 0, m_samt = 0, m_total = 0;

  // Compare DUT against model each cycle, then advance the model on the
  // inputs the DUT will sample at the next edge.
  initial begin
    @(posedge clock);
    forever begin
      @(negedge clock);
      chk("req_ready", req_ready, m_idle);
      chk("dime_out", dime_out, cyc == m_dime);
      chk("nickel_out", nickel_out, cyc == m_nick);
      chk("done", done, cyc == m_done);
      chk("short", short, m_short);
      chk("short_amount", short_amount, m_samt);
      chk("dime_stock", dime_stock, m_d);
      chk("nickel_stock", nickel_stock, m_n);
`ifdef CHANGE_DISPENSER_AUDIT_EN
      chk("paid_total", paid_total, m_total);
`endif
      if (dime_out === 1'b1)   dq.push_back(cyc);
      if (nickel_out === 1'b1) nq.push_back(cyc);
      if (reset) begin
        m_idle = 1; m_eval = -1; m_dime = -1; m_nick = -1; m_done = -1;
        m_rem = 0; m_d = DI; m_n = NI; m_short = 0; m_samt = 0; m_total = 0;
      end else if (m_idle) begin
        if (refill) begin m_d = DI; m_n = NI; end
        if (req_valid) begin
          m_idle = 0; m_rem = req_amount; m_eval = cyc + 1; m_short = 0; m_samt = 0;
        end
      end else if (cyc == m_eval) begin
        if (hopper_busy) m_eval = cyc + 1;
        else if (m_rem >= 2 && m_d > 0) begin
          m_rem -= 2; m_d--; m_total = (m_total + 2) % 65536; m_dime = cyc + 1; m_eval = cyc + 3;
        end else if (m_rem >= 1 && m_n > 0) begin
          m_rem -= 1; m_n--; m_total = (m_total + 1) % 65536; m_nick = cyc + 1; m_eval = cyc + 3;
        end else begin
          m_done = cyc + 1; m_short = (m_rem != 0); m_samt = m_rem; m_eval = -1;
        end
      end else if (cyc == m_done) m_idle = 1;
      cyc++;
    end
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  int t, done_rel;

  task automatic wait_ready();
    int k = 0;
    while (req_ready !== 1'b1 && k < 100) begin step(); k++; end
    if (k == 100) chk("ready_timeout", 0, 1);
  endtask

  // One request; busy held for nbusy cycles after acceptance, refill asserted
  // during those busy cycles when rmid is set (must be ignored). Returns at
  // the done cycle.
  task automatic req(input int amt, input int nbusy, input bit rmid);
    int k = 0;
    wait_ready();
    req_valid = 1'b1; req_amount = AMT_W'(amt); t = cyc;
    dq.delete(); nq.delete();
    step();
    req_valid = 1'b0; refill = 1'b0;
    for (int i = 0; i < nbusy; i++) begin hopper_busy = 1'b1; refill = rmid; step(); end
    hopper_busy = 1'b0; refill = 1'b0;
    while (done !== 1'b1 && k < 200) begin step(); k++; end
    if (k == 200) chk("done_timeout", 0, 1);
    done_rel = cyc - t;
  endtask

  function automatic int rel(input int q[$], input int i);
    return (q.size() > i) ? q[i] - t : -1;
  endfunction

  initial begin
    repeat (3) step();
    chk("rst req_ready", req_ready, 1);
    chk("rst dime_stock", dime_stock, 20);
    chk("rst nickel_stock", nickel_stock, 20);
    chk("rst short", short, 0);
    reset = 1'b0;
    step();

    // 15 cents: dime then nickel.
    req(3, 0, 0);
    chk("a3 dime_at", rel(dq, 0), 2);
    chk("a3 nickel_at", rel(nq, 0), 5);
    chk("a3 done_at", done_rel, 8);
    chk("a3 short", short, 0);
    chk("a3 dime_stock", dime_stock, 19);
    chk("a3 nickel_stock", nickel_stock, 19);
    chk("a3 coins", dq.size() + nq.size(), 2);

    // Zero amount.
    req(0, 0, 0);
    chk("a0 done_at", done_rel, 2);
    chk("a0 coins", dq.size() + nq.size(), 0);
    chk("a0 short", short, 0);
    chk("a0 dime_stock", dime_stock, 19);

    // Busy for 4 cycles; refill during payout is ignored.
    req(2, 4, 1);
    chk("busy dime_at", rel(dq, 0), 6);
    chk("busy done_at", done_rel, 9);
    chk("busy dime_stock", dime_stock, 18);

    // Reset mid-payout at T+5 of a 30-cent request.
    step(); wait_ready();
    req_valid = 1'b1; req_amount = AMT_W'(6); t = cyc; dq.delete(); nq.delete();
    step(); req_valid = 1'b0;
    repeat (4) step();
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst_mid req_ready", req_ready, 1);
    chk("rst_mid dime_stock", dime_stock, 20);
    chk("rst_mid nickel_stock", nickel_stock, 20);
`ifdef CHANGE_DISPENSER_AUDIT_EN
    chk("rst_mid paid_total", paid_total, 0);
`endif
    repeat (10) step();
    chk("rst_mid dimes", dq.size(), 2);
    chk("rst_mid nickels", nq.size(), 0);

    req(6, 0, 0);
    chk("a6 done_at", done_rel, 11);
    chk("a6 dime_stock", dime_stock, 17);
`ifdef CHANGE_DISPENSER_AUDIT_EN
    chk("a6 paid_total", paid_total, 6);
`endif

    // Exhaust dimes: 17 -> 10 -> 3 -> 0.
    req(15, 0, 0); req(15, 0, 0); req(6, 0, 0);
    chk("drain dime_stock", dime_stock, 0);
    chk("drain nickel_stock", nickel_stock, 18);
    req(4, 0, 0);
    chk("nk n0", rel(nq, 0), 2);
    chk("nk n1", rel(nq, 1), 5);
    chk("nk n2", rel(nq, 2), 8);
    chk("nk n3", rel(nq, 3), 11);
    chk("nk done_at", done_rel, 14);
    chk("nk nickel_stock", nickel_stock, 14);
    chk("nk dimes", dq.size(), 0);

    // Refill, then exhaust nickels one at a time.
    step(); wait_ready();
    refill = 1'b1; step(); refill = 1'b0;
    for (int i = 0; i < 20; i++) req(1, 0, 0);
    chk("ndrain nickel_stock", nickel_stock, 0);
    req(5, 0, 0);
    chk("sh d0", rel(dq, 0), 2);
    chk("sh d1", rel(dq, 1), 5);
    chk("sh done_at", done_rel, 8);
    chk("sh short", short, 1);
    chk("sh short_amount", short_amount, 1);
    step();
    chk("sh held", short, 1);

    // rem=1 with no nickels: never pay a dime.
    req(1, 0, 0);
    chk("r1 done_at", done_rel, 2);
    chk("r1 coins", dq.size() + nq.size(), 0);
    chk("r1 short_amount", short_amount, 1);

    // Refill and request in the same cycle.
    step(); wait_ready();
    refill = 1'b1;
    req(1, 0, 0);
    chk("rf nickel_at", rel(nq, 0), 2);
    chk("rf done_at", done_rel, 5);
    chk("rf short", short, 0);
    chk("rf nickel_stock", nickel_stock, 19);
    chk("rf dime_stock", dime_stock, 20);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
